// File: rtl/audio_output_multi_if.sv
//------------------------------------------------------------------------------
// audio_output_multi_if : valid/ready sample-word write port for audio_output_multi
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface audio_output_multi_if #(
   parameter int WIDTH = 32
) ();
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/audio_output_multi.sv
//------------------------------------------------------------------------------
// audio_output_multi : FIFO-buffered N-channel first-order delta-sigma audio DAC
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module audio_output_multi #(
   parameter int CHANNELS           = 2,
   parameter int SAMPLE_WIDTH       = 16,
   parameter int FIFO_DEPTH_IN_BITS = 3,
   parameter int SIGNED_INPUT       = 0,
   parameter int UNDERRUN_MODE      = 0
) (
   input  wire logic                          clk,
   input  wire logic                          reset,
   audio_output_multi_if.slave                wr_if,
   input  wire logic [31:0]                   clock_divider_i,
   input  wire logic                          enable_i,
   output logic                               underrun_o,
   input  wire logic                          underrun_clear_i,
   output logic [FIFO_DEPTH_IN_BITS:0]        fill_level_o,
   output logic [CHANNELS-1:0]                audio_out_o
);
   localparam int c_word_w = CHANNELS * SAMPLE_WIDTH;
   localparam int c_depth  = 1 << FIFO_DEPTH_IN_BITS;
   localparam logic [FIFO_DEPTH_IN_BITS:0] c_full = (FIFO_DEPTH_IN_BITS+1)'(c_depth);
   localparam logic [SAMPLE_WIDTH-1:0]     c_mid  = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

   function automatic logic [SAMPLE_WIDTH-1:0] conv(input logic [SAMPLE_WIDTH-1:0] w);
      logic [SAMPLE_WIDTH-1:0] r;
      r = w;
      if (SIGNED_INPUT != 0) r[SAMPLE_WIDTH-1] = ~w[SAMPLE_WIDTH-1];
      return r;
   endfunction

   logic [c_word_w-1:0]                    mem_q [c_depth];
   logic [FIFO_DEPTH_IN_BITS-1:0]          wr_ptr_q, rd_ptr_q;
   logic [FIFO_DEPTH_IN_BITS:0]            count_q, count_d;
   logic [31:0]                            div_cnt_q, div_cnt_d;
   logic                                   tick, push, pop, empty;
   logic                                   pop_q, starve_q, underrun_q;
   logic [c_word_w-1:0]                    rdata_q;
   logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0]  sample_q;
   logic [CHANNELS-1:0][SAMPLE_WIDTH:0]    acc_q;

   assign empty        = (count_q == '0);
   assign wr_if.ready  = !reset && (count_q != c_full);
   assign push         = wr_if.valid && wr_if.ready;
   assign tick         = enable_i && (div_cnt_q == 32'd0);
   assign pop          = tick && !empty;
   assign fill_level_o = count_q;
   assign underrun_o   = underrun_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (FIFO_DEPTH_IN_BITS+1)'(1);
         2'b01:   count_d = count_q - (FIFO_DEPTH_IN_BITS+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Counter parks at zero while disabled so the first enabled cycle ticks.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (!enable_i)                div_cnt_d = 32'd0;
      else if (div_cnt_q == 32'd0)  div_cnt_d = clock_divider_i;
      else                          div_cnt_d = div_cnt_q - 32'd1;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_if.data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         div_cnt_q  <= 32'd0;
         pop_q      <= 1'b0;
         starve_q   <= 1'b0;
         rdata_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         div_cnt_q <= div_cnt_d;
         pop_q     <= pop;
         starve_q  <= tick && empty;
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_IN_BITS'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_IN_BITS'(1);
            rdata_q  <= mem_q[rd_ptr_q];
         end
         if (tick && empty)         underrun_q <= 1'b1;
         else if (underrun_clear_i) underrun_q <= 1'b0;
      end
   end

   // Sample regs follow the pop (or starved tick) by one cycle; accumulators run always.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            sample_q[k] <= conv('0);
            acc_q[k]    <= '0;
         end
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (pop_q)
               sample_q[k] <= conv(rdata_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            else if (starve_q && (UNDERRUN_MODE != 0))
               sample_q[k] <= c_mid;
            acc_q[k] <= {1'b0, acc_q[k][SAMPLE_WIDTH-1:0]} + {1'b0, sample_q[k]};
         end
      end
   end

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_out
         assign audio_out_o[k] = acc_q[k][SAMPLE_WIDTH];
      end
   endgenerate
endmodule

`default_nettype wire
